// File: rtl/cla_pipe_addsub_pkg.sv
// cla_pipe_addsub_pkg: default widths and pipeline-depth derivation shared by the adder, its interface and benches
package cla_pipe_addsub_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_GROUP = 4;
  function automatic int lat(input int width, input int group);
    return width / group;
  endfunction
endpackage

// File: rtl/cla_pipe_addsub_if.sv
// cla_pipe_addsub_if: operand (in_*) and result (out_*) valid/ready channels; master = producer/consumer side, slave = adder
interface cla_pipe_addsub_if
  import cla_pipe_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/cla_pipe_addsub_group.sv
// cla_pipe_addsub_group: combinational N-bit lookahead group; a/b/cin in, sum, group carry-out and carry into the top bit out
module cla_pipe_addsub_group #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         cmsb
);
  logic [N-1:0] g, p, gg, pp;
  logic [N:0]   cc;
  always_comb begin
    g = a & b;
    p = a ^ b;
    gg[0] = g[0];
    pp[0] = p[0];
    for (int i = 1; i < N; i++) begin
      gg[i] = g[i] | (p[i] & gg[i-1]);
      pp[i] = p[i] & pp[i-1];
    end
    cc[0] = cin;
    for (int i = 0; i < N; i++) cc[i+1] = gg[i] | (pp[i] & cin);
    sum = p ^ cc[N-1:0];
  end
  assign cout = cc[N];
  assign cmsb = cc[N-1];
endmodule

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined CLA add/sub resolving one GROUP per stage; clk, async rst_n, bus = operand/result handshakes
module cla_pipe_addsub
  import cla_pipe_addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input logic               clk,
  input logic               rst_n,
  cla_pipe_addsub_if.slave  bus
);
  localparam int LAT = lat(WIDTH, GROUP);
  if (WIDTH % GROUP != 0) begin : g_bad
    $error("WIDTH must be a multiple of GROUP");
  end
  logic [LAT-1:0]   v, c, adv;
  logic             m   [LAT];
  logic [WIDTH-1:0] a_q [LAT];
  logic [WIDTH-1:0] b_q [LAT];
  logic [WIDTH-1:0] s_q [LAT];
  assign bus.in_ready  = adv[0];
  assign bus.out_valid = v[LAT-1];
  assign bus.out_sum   = s_q[LAT-1];
  assign bus.out_cout  = c[LAT-1];
  assign bus.out_ovf   = c[LAT-1] ^ m[LAT-1];
  for (genvar s = 0; s < LAT; s++) begin : g_stage
    logic [WIDTH-1:0] a_i, b_i, s_i, s_n;
    logic [GROUP-1:0] g_s;
    logic             v_i, c_i, g_c, g_m;
    if (s == 0) begin : g_first
      assign v_i = bus.in_valid;
      assign a_i = bus.in_a;
      assign b_i = bus.in_sub ? ~bus.in_b : bus.in_b;
      assign c_i = bus.in_sub | bus.in_cin;
      assign s_i = '0;
    end else begin : g_next
      assign v_i = v[s-1];
      assign a_i = a_q[s-1];
      assign b_i = b_q[s-1];
      assign c_i = c[s-1];
      assign s_i = s_q[s-1];
    end
    if (s == LAT - 1) begin : g_last
      assign adv[s] = !v[s] | bus.out_ready;
    end else begin : g_mid
      assign adv[s] = !v[s] | adv[s+1];
    end
    cla_pipe_addsub_group #(.N(GROUP)) u_grp (
      .a    (a_i[s*GROUP +: GROUP]),
      .b    (b_i[s*GROUP +: GROUP]),
      .cin  (c_i),
      .sum  (g_s),
      .cout (g_c),
      .cmsb (g_m)
    );
    always_comb begin
      s_n = s_i;
      s_n[s*GROUP +: GROUP] = g_s;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v[s]   <= 1'b0;
        c[s]   <= 1'b0;
        m[s]   <= 1'b0;
        a_q[s] <= '0;
        b_q[s] <= '0;
        s_q[s] <= '0;
      end else if (adv[s]) begin
        v[s] <= v_i;
        if (v_i) begin
          c[s]   <= g_c;
          m[s]   <= g_m;
          a_q[s] <= a_i;
          b_q[s] <= b_i;
          s_q[s] <= s_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub: directed vectors, backpressure, async reset and randomized scoreboard runs on three configurations
module tb_cla_pipe_addsub;
  import cla_pipe_addsub_pkg::*;
  localparam int NRAND = 10000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  cla_pipe_addsub_if #(.WIDTH(16)) b16 ();
  cla_pipe_addsub_if #(.WIDTH(32)) b32 ();
  cla_pipe_addsub_if #(.WIDTH(8))  b8 ();
  cla_pipe_addsub #(.WIDTH(16), .GROUP(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  cla_pipe_addsub #(.WIDTH(32), .GROUP(8)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  cla_pipe_addsub #(.WIDTH(8),  .GROUP(8)) u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  int pass_cnt = 0;
  int total = 0;
  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] sum;
    logic        cout, ovf;
  } vec_t;
  vec_t vecs [8];
  task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    logic [63:0] msk, aa, bb, s;
    logic [64:0] full;
    logic co, ov;
    msk  = (64'd1 << w) - 64'd1;
    aa   = a & msk;
    bb   = (sub ? ~b : b) & msk;
    full = {1'b0, aa} + {1'b0, bb} + 65'(sub | cin);
    s    = full[63:0] & msk;
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {ov, co, s};
  endfunction
  task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                          output logic [15:0] sum, output logic cout, output logic ovf, output int n);
    int k;
    @(posedge clk); #1;
    b16.in_valid = 1'b1; b16.in_a = a; b16.in_b = b; b16.in_cin = cin; b16.in_sub = sub;
    b16.out_ready = 1'b1;
    @(negedge clk);
    k = 0;
    while (!b16.in_ready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!b16.out_valid && n < 20) begin @(posedge clk); n++; @(negedge clk); end
    sum = b16.out_sum; cout = b16.out_cout; ovf = b16.out_ovf;
    @(posedge clk); #1;
  endtask
  initial begin
    logic [15:0] sum, hold;
    logic cout, ovf;
    int n, acc, got, last, stale;
    logic [65:0] q[$], q16[$], q32[$], q8[$];
    int s16, s32, s8, n16, n32, n8;
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[6] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    b16.in_valid = 0; b16.in_a = '0; b16.in_b = '0; b16.in_cin = 0; b16.in_sub = 0; b16.out_ready = 0;
    b32.in_valid = 0; b32.in_a = '0; b32.in_b = '0; b32.in_cin = 0; b32.in_sub = 0; b32.out_ready = 0;
    b8.in_valid = 0;  b8.in_a = '0;  b8.in_b = '0;  b8.in_cin = 0;  b8.in_sub = 0;  b8.out_ready = 0;
    #2;
    check("rst out_valid", 66'(b16.out_valid), 66'(0));
    check("rst out_sum", 66'(b16.out_sum), 66'(0));
    check("rst cout/ovf", 66'({b16.out_cout, b16.out_ovf}), 66'(0));
    check("rst in_ready", 66'(b16.in_ready), 66'(1));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("post-rst in_ready", 66'(b16.in_ready), 66'(1));
    for (int i = 0; i < 8; i++) begin
      send_one(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, sum, cout, ovf, n);
      check($sformatf("vec%0d sum", i), 66'(sum), 66'(vecs[i].sum));
      check($sformatf("vec%0d cout", i), 66'(cout), 66'(vecs[i].cout));
      check($sformatf("vec%0d ovf", i), 66'(ovf), 66'(vecs[i].ovf));
      check($sformatf("vec%0d latency", i), 66'(n), 66'(lat(16, 4)));
    end
    acc = 0; got = 0; last = -1; hold = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(posedge clk); #1;
      b16.out_ready = (cyc >= 6);
      b16.in_valid = (acc < 8);
      b16.in_a = 16'(32'h1111 * (acc + 1));
      b16.in_b = 16'(32'h0F0F ^ (acc << 4));
      b16.in_cin = 1'b1;
      b16.in_sub = acc[0];
      @(negedge clk);
      if (cyc == 4) hold = b16.out_sum;
      if (cyc == 5) begin
        check("bp accepts", 66'(acc), 66'(4));
        check("bp in_ready", 66'(b16.in_ready), 66'(0));
        check("bp out_valid", 66'(b16.out_valid), 66'(1));
        check("bp stable", 66'(b16.out_sum), 66'(hold));
      end
      if (b16.in_valid && b16.in_ready) begin
        q.push_back(model(16, 64'(b16.in_a), 64'(b16.in_b), b16.in_cin, b16.in_sub));
        acc++;
      end
      if (b16.out_valid && b16.out_ready) begin
        if (q.size() == 0) check("bp underflow", 66'(q.size()), 66'(1));
        else check($sformatf("bp beat%0d", got), {b16.out_ovf, b16.out_cout, 64'(b16.out_sum)}, q.pop_front());
        if (got > 0) check("bp back-to-back", 66'(cyc), 66'(last + 1));
        last = cyc;
        got++;
      end
    end
    check("bp count", 66'(got), 66'(8));
    b16.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      b16.in_valid = 1'b1; b16.in_a = 16'(i * 3 + 1); b16.in_b = 16'h0100; b16.in_cin = 0; b16.in_sub = 0;
    end
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    @(negedge clk);
    check("mid pre-reset valid", 66'(b16.out_valid), 66'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 66'(b16.out_valid), 66'(0));
    check("mid reset out_sum", 66'(b16.out_sum), 66'(0));
    check("mid reset cout/ovf", 66'({b16.out_cout, b16.out_ovf}), 66'(0));
    check("mid reset in_ready", 66'(b16.in_ready), 66'(1));
    #1 rst_n = 1'b1;
    b16.out_ready = 1'b1;
    stale = 0;
    repeat (8) begin @(negedge clk); if (b16.out_valid) stale++; end
    check("no stale beat", 66'(stale), 66'(0));
    send_one(16'h00FF, 16'h0001, 1'b0, 1'b0, sum, cout, ovf, n);
    check("after reset sum", 66'({ovf, cout, sum}), 66'({2'b00, 16'h0100}));
    check("after reset latency", 66'(n), 66'(lat(16, 4)));
    s16 = 0; s32 = 0; s8 = 0; n16 = 0; n32 = 0; n8 = 0;
    for (int cyc = 0; cyc < 60000 && !(n16 >= NRAND && n32 >= NRAND && n8 >= NRAND); cyc++) begin
      @(posedge clk); #1;
      b16.in_valid = (s16 < NRAND) && ($urandom_range(0, 3) != 0);
      b16.in_a = 16'($urandom()); b16.in_b = 16'($urandom());
      b16.in_cin = 1'($urandom()); b16.in_sub = 1'($urandom());
      b16.out_ready = ($urandom_range(0, 3) != 0);
      b32.in_valid = (s32 < NRAND) && ($urandom_range(0, 3) != 0);
      b32.in_a = $urandom(); b32.in_b = $urandom();
      b32.in_cin = 1'($urandom()); b32.in_sub = 1'($urandom());
      b32.out_ready = ($urandom_range(0, 3) != 0);
      b8.in_valid = (s8 < NRAND) && ($urandom_range(0, 3) != 0);
      b8.in_a = 8'($urandom()); b8.in_b = 8'($urandom());
      b8.in_cin = 1'($urandom()); b8.in_sub = 1'($urandom());
      b8.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (b16.in_valid && b16.in_ready) begin
        q16.push_back(model(16, 64'(b16.in_a), 64'(b16.in_b), b16.in_cin, b16.in_sub)); s16++;
      end
      if (b16.out_valid && b16.out_ready) begin
        n16++;
        if (q16.size() == 0) check("r16 underflow", 66'(q16.size()), 66'(1));
        else check("r16 result", {b16.out_ovf, b16.out_cout, 64'(b16.out_sum)}, q16.pop_front());
      end
      if (b32.in_valid && b32.in_ready) begin
        q32.push_back(model(32, 64'(b32.in_a), 64'(b32.in_b), b32.in_cin, b32.in_sub)); s32++;
      end
      if (b32.out_valid && b32.out_ready) begin
        n32++;
        if (q32.size() == 0) check("r32 underflow", 66'(q32.size()), 66'(1));
        else check("r32 result", {b32.out_ovf, b32.out_cout, 64'(b32.out_sum)}, q32.pop_front());
      end
      if (b8.in_valid && b8.in_ready) begin
        q8.push_back(model(8, 64'(b8.in_a), 64'(b8.in_b), b8.in_cin, b8.in_sub)); s8++;
      end
      if (b8.out_valid && b8.out_ready) begin
        n8++;
        if (q8.size() == 0) check("r8 underflow", 66'(q8.size()), 66'(1));
        else check("r8 result", {b8.out_ovf, b8.out_cout, 64'(b8.out_sum)}, q8.pop_front());
      end
    end
    check("r16 count", 66'(n16), 66'(NRAND));
    check("r32 count", 66'(n32), 66'(NRAND));
    check("r8 count", 66'(n8), 66'(NRAND));
    check("queues drained", 66'(q16.size() + q32.size() + q8.size()), 66'(0));
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
